// File: rtl/regfile_dump_unit.sv
// Sweeps the register file two registers per fetch and streams every register out as an (addr, data) word.
// Latency: start at edge 0 -> done during cycle 3*NUM_REGS/2+1 with no stalls; out_valid/out_addr/out_data hold while out_ready is low.
// Build option REGDUMP_SKIP_R0_EN: pair 0 skips SEND_A so register 0 is never emitted.
module regfile_dump_unit #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] read_reg_a_addr,
  output logic [ADDR_WIDTH-1:0] read_reg_b_addr,
  input  logic [DATA_WIDTH-1:0] reg_a_data_in,
  input  logic [DATA_WIDTH-1:0] reg_b_data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = ADDR_WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS / 2 - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_SEND_A = 3'd2;
  localparam logic [2:0] S_SEND_B = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] buf_a_q, buf_a_d;
  logic [DATA_WIDTH-1:0] buf_b_q, buf_b_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_FETCH: begin
        // Both halves of the pair are snapshotted here; later register writes cannot leak in.
        buf_a_d = reg_a_data_in;
        buf_b_d = reg_b_data_in;
`ifdef REGDUMP_SKIP_R0_EN
        state_d = (idx_q == '0) ? S_SEND_B : S_SEND_A;
`else
        state_d = S_SEND_A;
`endif
      end
      S_SEND_A: begin
        if (out_ready) state_d = S_SEND_B;
      end
      S_SEND_B: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_a_q <= '0;
      buf_b_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset drops them immediately.
  assign read_reg_a_addr = {idx_q, 1'b0};
  assign read_reg_b_addr = {idx_q, 1'b1};
  assign out_valid       = (state_q == S_SEND_A) || (state_q == S_SEND_B);
  assign out_addr        = {idx_q, (state_q == S_SEND_B)};
  assign out_data        = (state_q == S_SEND_B) ? buf_b_q : buf_a_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: bench-side register file, expected-word queue and per-cycle checker.
module tb_regfile_dump_unit;

`ifdef REGDUMP_SKIP_R0_EN
  localparam int FIRST_REG  = 1;
  localparam int EXP_WORDS  = 31;
  localparam int EXP_DONE_C = 48;
  localparam logic [31:0] FIRST_DATA_LIT = 32'hA5000001;
`else
  localparam int FIRST_REG  = 0;
  localparam int EXP_WORDS  = 32;
  localparam int EXP_DONE_C = 49;
  localparam logic [31:0] FIRST_DATA_LIT = 32'hA5000000;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  read_reg_a_addr, read_reg_b_addr, out_addr;
  logic [31:0] reg_a_data_in, reg_b_data_in, out_data;
  logic        out_valid, busy, done;

  logic [31:0] regs [32];

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } word_t;
  word_t expq[$];

  int errors = 0;
  int checks = 0;
  int words = 0;
  int done_cnt = 0;
  int done_cycle = 0;
  int ready_mode = 0;
  int rcyc = 0;
  time t0 = 0;
  logic [4:0]  first_addr, last_addr;
  logic [31:0] first_data, last_data;
  logic [31:0] seen_data [32];
  bit          stall_prev = 0;
  logic [4:0]  prev_addr;
  logic [31:0] prev_data;

  regfile_dump_unit dut (
    .clock(clock), .reset(reset), .start(start),
    .read_reg_a_addr(read_reg_a_addr), .read_reg_b_addr(read_reg_b_addr),
    .reg_a_data_in(reg_a_data_in), .reg_b_data_in(reg_b_data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  assign reg_a_data_in = regs[read_reg_a_addr];
  assign reg_b_data_in = regs[read_reg_b_addr];

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer readiness: always ready, or ready one cycle in three.
  always @(posedge clock) begin
    #1;
    rcyc++;
    out_ready = (ready_mode == 0) ? 1'b1 : ((rcyc % 3) == 0);
  end

  always @(negedge clock) begin
    if (reset) begin
      if (stall_prev) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_addr", {59'd0, out_addr}, {59'd0, prev_addr});
        chk("hold_data", {32'd0, out_data}, {32'd0, prev_data});
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got addr %0d with nothing expected", out_addr);
        end else begin
          chk("word_addr", {59'd0, out_addr}, {59'd0, expq[0].addr});
          chk("word_data", {32'd0, out_data}, {32'd0, expq[0].data});
          void'(expq.pop_front());
        end
        if (words == 0) begin
          first_addr = out_addr;
          first_data = out_data;
        end
        last_addr = out_addr;
        last_data = out_data;
        seen_data[out_addr] = out_data;
        words++;
      end
      if (done) begin
        done_cnt++;
        done_cycle = int'((($time - t0) - 5) / 10) + 1;
        chk("done_drained", 64'(expq.size()), 64'd0);
      end
      stall_prev = out_valid && !out_ready;
      prev_addr  = out_addr;
      prev_data  = out_data;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic start_dump();
    expq.delete();
    for (int i = FIRST_REG; i < 32; i++) expq.push_back('{addr: 5'(i), data: regs[i]});
    words = 0;
    done_cnt = 0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); t0 = $time;
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clock);
      if (done) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done pulse expected one within 600 cycles", tag);
    end
    @(posedge clock); #1;
    chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({tag, "_words"}, 64'(words), 64'(EXP_WORDS));
  endtask

  task automatic wait_negedge_until_addr(input logic [4:0] a, input string tag);
    bit ok = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clock);
      if (out_valid && out_addr == a) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: got no word at addr %0d expected one", tag, a);
    end
  endtask

  initial begin
    int wsave;
    bit ok;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA5000000 + i;
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_raddr_a", {59'd0, read_reg_a_addr}, 64'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Full dump, no stalls
    ready_mode = 0;
    start_dump();
    wait_done("basic");
    chk("basic_latency", 64'(done_cycle), 64'(EXP_DONE_C));
    chk("basic_first_addr", {59'd0, first_addr}, 64'(FIRST_REG));
    chk("basic_first_data", {32'd0, first_data}, {32'd0, FIRST_DATA_LIT});
    chk("basic_last_addr", {59'd0, last_addr}, 64'd31);
    chk("basic_last_data", {32'd0, last_data}, 64'hA500001F);
    chk("idle_raddr_a", {59'd0, read_reg_a_addr}, 64'd0);
    chk("idle_raddr_b", {59'd0, read_reg_b_addr}, 64'd1);

    // Backpressure: ready one cycle in three
    ready_mode = 1;
    start_dump();
    wait_done("stall");
    chk("stall_last_addr", {59'd0, last_addr}, 64'd31);
    ready_mode = 0;

    // Start pulsed mid-dump is ignored
    start_dump();
    ok = 0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clock); #1;
      if (words >= 10) begin ok = 1; break; end
    end
    chk("restart_reached_w10", {63'd0, ok}, 64'd1);
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_done("restart");
    chk("restart_latency", 64'(done_cycle), 64'(EXP_DONE_C));
    repeat (8) @(posedge clock);
    #1;
    chk("restart_no_queue_busy", {63'd0, busy}, 64'd0);
    chk("restart_no_queue_done", 64'(done_cnt), 64'd1);

    // Asynchronous reset during SEND_B of pair 5
    start_dump();
    wait_negedge_until_addr(5'd11, "abort_reach_pair5");
    #2 reset = 1'b0;
    #1;
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_raddr_a", {59'd0, read_reg_a_addr}, 64'd0);
    wsave = words;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    expq.delete();
    repeat (6) @(posedge clock);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_no_words", 64'(words), 64'(wsave));
    start_dump();
    wait_done("after_abort");
    chk("after_abort_first", {59'd0, first_addr}, 64'(FIRST_REG));

    // Snapshot: reg[4] written right after pair-2 fetch
    start_dump();
    ok = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clock);
      if (busy && !out_valid && !done && read_reg_a_addr == 5'd4) begin ok = 1; break; end
    end
    chk("snap_saw_fetch2", {63'd0, ok}, 64'd1);
    @(posedge clock); #1 regs[4] = 32'hDEADBEEF;
    wait_done("snap1");
    chk("snap1_reg4", {32'd0, seen_data[4]}, 64'hA5000004);
    start_dump();
    wait_done("snap2");
    chk("snap2_reg4", {32'd0, seen_data[4]}, 64'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
